// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/logic/compare, iterative
// shift-add multiply and restoring divide/remainder, optional saturation.

package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_EQ  = 4'd7,
    OP_NEQ = 4'd8,
    OP_LT  = 4'd9,
    OP_LTE = 4'd10,
    OP_GT  = 4'd11,
    OP_GTE = 4'd12,
    OP_DIV = 4'd13,
    OP_REM = 4'd14
  } alu_op_e;
endpackage

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             over,
  output logic             under,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   a_q, b_q, mb_q;
  logic               neg_a_q, neg_b_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   out_q;
  logic               over_q, under_q, dz_q;
  logic               in_ready_q, out_valid_q;

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] bool_f(input logic b);
    return {{(WIDTH-1){1'b0}}, b};
  endfunction

  function automatic logic [WIDTH-1:0] sat_f(input logic [WIDTH-1:0] v,
                                             input logic ov, input logic un);
    if (SATURATE && ov) return MAX_V;
    if (SATURATE && un) return MIN_V;
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs at accept time
  // ---------------------------------------------------------------------
  logic signed [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0]        add_r, sub_r;
  logic [WIDTH-1:0]        sc_out;
  logic                    sc_over, sc_under;
  logic                    is_iter;

  assign s1      = input1;
  assign s2      = input2;
  assign add_r   = input1 + input2;
  assign sub_r   = input1 - input2;
  assign is_iter = (alu_sel == OP_MUL) || (alu_sel == OP_DIV) || (alu_sel == OP_REM);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    sc_out   = '0;
    sc_over  = 1'b0;
    sc_under = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        sc_out   = add_r;
        sc_over  = ~input1[WIDTH-1] & ~input2[WIDTH-1] &  add_r[WIDTH-1];
        sc_under =  input1[WIDTH-1] &  input2[WIDTH-1] & ~add_r[WIDTH-1];
      end
      OP_SUB: begin
        sc_out   = sub_r;
        sc_over  = ~input1[WIDTH-1] &  input2[WIDTH-1] &  sub_r[WIDTH-1];
        sc_under =  input1[WIDTH-1] & ~input2[WIDTH-1] & ~sub_r[WIDTH-1];
      end
      OP_AND:  sc_out = input1 & input2;
      OP_OR:   sc_out = input1 | input2;
      OP_XOR:  sc_out = input1 ^ input2;
      OP_NOT:  sc_out = ~input2;
      OP_EQ:   sc_out = bool_f(s1 == s2);
      OP_NEQ:  sc_out = bool_f(s1 != s2);
      OP_LT:   sc_out = bool_f(s1 <  s2);
      OP_LTE:  sc_out = bool_f(s1 <= s2);
      OP_GT:   sc_out = bool_f(s1 >  s2);
      OP_GTE:  sc_out = bool_f(s1 >= s2);
      default: sc_out = '0;
    endcase
    sc_out = sat_f(sc_out, sc_over, sc_under);
  end

  // ---------------------------------------------------------------------
  // Iterative engine: acc_q holds {high, low} halves of the product, or
  // {partial remainder, quotient/dividend shift register} for division.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rs, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   acc_d;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Partial remainder stays below the divisor magnitude, so its top bit is free.
  assign div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_rs - {1'b0, mb_q};
  assign div_next = div_diff[WIDTH] ? {div_rs[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign acc_d = (op_q == OP_MUL) ? mul_next : div_next;

  // ---------------------------------------------------------------------
  // Sign fix-up and flags for the last engine step
  // ---------------------------------------------------------------------
  logic               neg_p;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_ovf;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   fin_out;
  logic               fin_over, fin_under, fin_dz;

  assign neg_p   = neg_a_q ^ neg_b_q;
  assign prod_s  = neg_p ? -acc_d : acc_d;
  assign mul_ovf = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
  assign quo_s   = neg_p   ? -acc_d[WIDTH-1:0]       : acc_d[WIDTH-1:0];
  assign rem_s   = neg_a_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

  always_comb begin
    fin_out   = '0;
    fin_over  = 1'b0;
    fin_under = 1'b0;
    fin_dz    = 1'b0;
    if (op_q == OP_MUL) begin
      fin_out   = prod_s[WIDTH-1:0];
      fin_over  = mul_ovf & ~neg_p;
      fin_under = mul_ovf &  neg_p;
    end else if (mb_q == '0) begin
      fin_dz  = 1'b1;
      fin_out = (op_q == OP_DIV) ? '1 : a_q;
    end else if (a_q == MIN_V && b_q == '1) begin
      fin_over = 1'b1;
      fin_out  = (op_q == OP_DIV) ? MIN_V : '0;
    end else begin
      fin_out = (op_q == OP_DIV) ? quo_s : rem_s;
    end
    fin_out = sat_f(fin_out, fin_over, fin_under);
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      mb_q        <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      over_q      <= 1'b0;
      under_q     <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= alu_op_e'(alu_sel);
            a_q        <= input1;
            b_q        <= input2;
            mb_q       <= abs_f(input2);
            neg_a_q    <= input1[WIDTH-1];
            neg_b_q    <= input2[WIDTH-1];
            in_ready_q <= 1'b0;
            if (is_iter) begin
              state_q <= S_BUSY;
              cnt_q   <= CW'(WIDTH - 1);
              acc_q   <= {{WIDTH{1'b0}}, abs_f(input1)};
            end else begin
              state_q     <= S_DONE;
              out_q       <= sc_out;
              over_q      <= sc_over;
              under_q     <= sc_under;
              dz_q        <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            out_q       <= fin_out;
            over_q      <= fin_over;
            under_q     <= fin_under;
            dz_q        <= fin_dz;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign over      = over_q;
  assign under     = under_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: wrapping and saturating instances share
// stimulus; directed vectors, corner sequences and a randomized model check.

module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam logic [31:0] MAX32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN32 = 32'h8000_0000;
  localparam longint      MAXL  = 64'sd2147483647;
  localparam longint      MINL  = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] input1, input2;
  logic [3:0]  alu_sel;

  logic        in_ready_w, out_valid_w, over_w, under_w, div_zero_w;
  logic [31:0] out_w;
  logic        in_ready_s, out_valid_s, over_s, under_s, div_zero_s;
  logic [31:0] out_s;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .input1(input1), .input2(input2), .alu_sel(alu_sel),
    .out_valid(out_valid_w), .out_ready(out_ready), .out(out_w),
    .over(over_w), .under(under_w), .div_zero(div_zero_w)
  );

  alu_seq #(.WIDTH(32), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .input1(input1), .input2(input2), .alu_sel(alu_sel),
    .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s),
    .over(over_s), .under(under_s), .div_zero(div_zero_s)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_overlap = 0;

  always @(negedge clk)
    if (!rst && ((in_ready_w && out_valid_w) || (in_ready_s && out_valid_s)))
      n_overlap++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: true mathematical result, then range check.
  typedef struct packed {
    logic [31:0] out;
    logic [2:0]  fl;   // {over, under, div_zero}
  } res_t;

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit sat);
    longint sa, sb, t;
    res_t   r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = 0;
    r.out = '0;
    r.fl  = 3'b000;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: begin
        if (op == OP_ADD)      t = sa + sb;
        else if (op == OP_SUB) t = sa - sb;
        else                   t = sa * sb;
        r.out = t[31:0];
        if (t > MAXL)      r.fl = 3'b100;
        else if (t < MINL) r.fl = 3'b010;
      end
      OP_DIV, OP_REM: begin
        if (b == 32'd0) begin
          r.fl  = 3'b001;
          r.out = (op == OP_DIV) ? 32'hFFFF_FFFF : a;
        end else if (a == MIN32 && b == 32'hFFFF_FFFF) begin
          r.fl  = 3'b100;
          r.out = (op == OP_DIV) ? MIN32 : 32'd0;
        end else begin
          t = (op == OP_DIV) ? sa / sb : sa % sb;
          r.out = t[31:0];
        end
      end
      OP_AND: r.out = a & b;
      OP_OR:  r.out = a | b;
      OP_XOR: r.out = a ^ b;
      OP_NOT: r.out = ~b;
      OP_EQ:  r.out = {31'd0, sa == sb};
      OP_NEQ: r.out = {31'd0, sa != sb};
      OP_LT:  r.out = {31'd0, sa <  sb};
      OP_LTE: r.out = {31'd0, sa <= sb};
      OP_GT:  r.out = {31'd0, sa >  sb};
      OP_GTE: r.out = {31'd0, sa >= sb};
      default: r.out = '0;
    endcase
    if (sat && r.fl == 3'b100) r.out = MAX32;
    if (sat && r.fl == 3'b010) r.out = MIN32;
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    return (op == OP_MUL || op == OP_DIV || op == OP_REM) ? 33 : 1;
  endfunction

  // Captured at the first cycle out_valid is seen.
  int          lat;
  logic [31:0] got_w, got_s;
  logic [2:0]  fl_w, fl_s;
  logic        vld_s;

  // Starts and ends on a falling edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noise);
    check("in_ready_at_issue", in_ready_w, 1);
    in_valid = 1'b1;
    alu_sel  = op;
    input1   = a;
    input2   = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_w && lat < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        alu_sel  = 4'($urandom_range(0, 14));
        input1   = $urandom;
        input2   = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    got_w = out_w;
    got_s = out_s;
    fl_w  = {over_w, under_w, div_zero_w};
    fl_s  = {over_s, under_s, div_zero_s};
    vld_s = out_valid_s;
  endtask

  task automatic drain(input int hold, input logic [31:0] exp_out, input logic [2:0] exp_fl);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid_w, 1);
      check("hold_out", out_w, exp_out);
      check("hold_flags", {over_w, under_w, div_zero_w}, exp_fl);
      check("hold_in_ready", in_ready_w, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", in_ready_w, 1);
    check("release_valid", out_valid_w, 0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] exp_w;
    logic [2:0]  fl;
    logic [31:0] exp_s;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    res_t rw, rs;
    int   busy_valid;

    vecs.push_back('{OP_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 3'b100, 32'h7FFF_FFFF, 1});
    vecs.push_back('{OP_MUL, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 3'b000, 32'hFFFF_FFD6, 33});
    vecs.push_back('{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,         3'b100, 32'h7FFF_FFFF, 33});
    vecs.push_back('{OP_MUL, 32'hFFFF_0000, 32'h0001_0000, 32'h0,         3'b010, 32'h8000_0000, 33});
    vecs.push_back('{OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b100, 32'h7FFF_FFFF, 33});
    vecs.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 3'b000, 32'hFFFF_FFFD, 33});
    vecs.push_back('{OP_REM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 33});
    vecs.push_back('{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b100, 32'h7FFF_FFFF, 33});
    vecs.push_back('{OP_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 3'b001, 32'hFFFF_FFFF, 33});
    vecs.push_back('{OP_REM, 32'd5,         32'd0,         32'd5,         3'b001, 32'd5,         33});
    vecs.push_back('{OP_SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 3'b010, 32'h8000_0000, 1});
    vecs.push_back('{OP_NOT, 32'h1234_5678, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000, 32'hF0F0_F0F0, 1});
    vecs.push_back('{OP_GTE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         3'b000, 32'd1,         1});
    vecs.push_back('{OP_GT,  32'hFFFF_FFFF, 32'd1,         32'd0,         3'b000, 32'd0,         1});

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    alu_sel = '0;
    input1 = '0;
    input2 = '0;
    #1;
    check("rst_in_ready", in_ready_w, 1);
    check("rst_out_valid", out_valid_w, 0);
    check("rst_out", out_w, 0);
    check("rst_flags", {over_w, under_w, div_zero_w, over_s, under_s, div_zero_s}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d out_wrap", i), got_w, vecs[i].exp_w);
      check($sformatf("vec%0d flags_wrap", i), fl_w, vecs[i].fl);
      check($sformatf("vec%0d out_sat", i), got_s, vecs[i].exp_s);
      check($sformatf("vec%0d flags_sat", i), fl_s, vecs[i].fl);
      drain(0, vecs[i].exp_w, vecs[i].fl);
    end

    // Backpressure: result held for 10 cycles, then released
    do_op(OP_LT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("bp latency", lat, 1);
    check("bp out", got_w, 1);
    drain(10, 32'd1, 3'b000);

    // Reset in the 10th BUSY cycle of a multiply
    in_valid = 1'b1;
    alu_sel  = OP_MUL;
    input1   = 32'hFFFF_FFF9;
    input2   = 32'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst busy", in_ready_w, 0);
    #2 rst = 1'b1;
    #1;
    check("abort out_valid", out_valid_w, 0);
    check("abort in_ready", in_ready_w, 1);
    check("abort out", out_w, 0);
    @(negedge clk);
    rst = 1'b0;
    busy_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_w || out_valid_s) busy_valid++;
    end
    check("aborted op produced no result", busy_valid, 0);
    do_op(OP_ADD, 32'd2, 32'd3, 1'b0);
    check("post_rst add latency", lat, 1);
    check("post_rst add out", got_w, 5);
    check("post_rst add flags", fl_w, 0);
    drain(0, 32'd5, 3'b000);

    // Randomized against the reference model, with ignored requests while busy
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          hold;
      op = 4'($urandom_range(0, 14));
      a  = pick();
      b  = pick();
      rw = model(op, a, b, 1'b0);
      rs = model(op, a, b, 1'b1);
      do_op(op, a, b, 1'b1);
      check($sformatf("rnd%0d op%0d lat", n, op), lat, model_lat(op));
      check($sformatf("rnd%0d op%0d %h,%h out_wrap", n, op, a, b), got_w, rw.out);
      check($sformatf("rnd%0d op%0d %h,%h flags_wrap", n, op, a, b), fl_w, rw.fl);
      check($sformatf("rnd%0d op%0d %h,%h out_sat", n, op, a, b), got_s, rs.out);
      check($sformatf("rnd%0d op%0d %h,%h flags_sat", n, op, a, b), fl_s, rs.fl);
      check($sformatf("rnd%0d valid_sat", n), vld_s, 1);
      hold = $urandom_range(0, 2);
      drain(hold, rw.out, rw.fl);
    end

    check("in_ready never with out_valid", n_overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MIN32;
      4: return MAX32;
      5, 6: return 32'($signed($urandom_range(0, 200)) - 100);
      default: return $urandom;
    endcase
  endfunction

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational ALU. Single-cycle ops (add/sub/logic/compare) return a registered result one cycle after acceptance. Multiply and the new divide/remainder ops run as iterative multi-cycle engines, which removes the wide combinational multiplier from the datapath. It sits between the decode stage and the register writeback, with valid/ready handshakes on both sides. An optional saturation mode clamps results on overflow or underflow.

## Interface
- WIDTH, 32: operand and result width in bits (≥ 4).
- SATURATE, 0: 1 = clamp `out` on over/under; 0 = wrap.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- input1  input  WIDTH  operand A (two's complement).
- input2  input  WIDTH  operand B (two's complement).
- alu_sel  input  4  opcode from opcodes.vh: ADD, SUB, MUL, AND, OR, XOR, NOT, EQ, NEQ, LT, LTE, GT, GTE, plus DIV and REM (added to opcodes.vh); any other code is undefined.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- over  output  1  signed positive overflow.
- under  output  1  signed negative overflow.
- div_zero  output  1  DIV/REM with input2 == 0.

## Operation
- Operands and opcode are latched on accept (`in_valid & in_ready`). Inputs are don't-care afterwards.
- States:
  - IDLE: `in_ready` = 1. On accept of MUL, DIV or REM, go to BUSY. On accept of any other opcode, go to DONE with the result computed.
  - BUSY: runs the iterative engine. The counter goes from WIDTH−1 down to 0. When it reaches 0, go to DONE.
  - DONE: `out_valid` = 1. The result and flags are held stable until `out_ready`. On `out_valid & out_ready`, go to IDLE.
- ADD/SUB: WIDTH-bit two's complement.
  - `over` is set when two non-negative operands (A and B for ADD, A and −B for SUB) give a negative result.
  - `under` is the mirror case: two negative operands give a non-negative result.
- MUL: magnitudes are multiplied by shift-add, one bit per cycle, into a 2·WIDTH product. The sign is applied at the end.
  - If the upper WIDTH bits of the product are not the sign extension of the low WIDTH bits, the op overflowed.
  - On overflow, `under` is set if the operand signs differ; otherwise `over` is set.
- DIV/REM: restoring division on magnitudes, one quotient bit per cycle.
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - MIN/−1 (MIN = most-negative value): `over` = 1, DIV result = MIN, REM result = 0.
  - input2 == 0: `div_zero` = 1, DIV result = all ones, REM result = input1, `over`/`under` = 0. The op still takes full latency.
- AND/OR/XOR: bitwise. NOT returns ~input2.
- Compares (EQ/NEQ/LT/LTE/GT/GTE) are signed and return 1 or 0, zero-extended to WIDTH.
- Saturation (SATURATE = 1):
  - `over` forces `out` = MAX (0111…1).
  - `under` forces `out` = MIN (1000…0).
  - The flags still assert. `div_zero` results are not clamped.
- Only one flag among `over`, `under`, `div_zero` is ever high. All flags are 0 for logic and compare ops.

## Timing
- Reset: state = IDLE, `in_ready` = 1, `out_valid` = 0, `out` = 0, and all flags = 0. This applies immediately (asynchronously).
- Reset during BUSY or DONE aborts the op and discards its result. No `out_valid` is produced for it.
- Latency, counted from the accept edge to `out_valid` being high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV/REM: WIDTH+1 cycles.
- Throughput:
  - With `out_ready` held high, a new accept can occur on the cycle after the handshake.
  - `in_ready` is never high in the same cycle as `out_valid`.
  - Peak rate is 1 op per 2 cycles for single-cycle ops.
- Backpressure: `out`, the flags and `out_valid` stay constant for as long as `out_valid & ~out_ready`.
- `in_valid` while `in_ready` = 0 is ignored. No request is buffered.
- `out`/flags are only meaningful while `out_valid` is high. Outside DONE they hold their last value.

## Test plan
All scenarios use WIDTH = 32.
- ADD 0x7FFFFFFF + 0x00000001:
  - SATURATE = 0 → `out` = 0x80000000, `over` = 1, `out_valid` 1 cycle after accept.
  - SATURATE = 1 → `out` = 0x7FFFFFFF, `over` = 1.
- MUL −7 × 6 → `out` = 0xFFFFFFD6, flags 0, `out_valid` exactly 33 cycles after accept. MUL 0x00010000 × 0x00010000 → `out` = 0, `over` = 1.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIV 0x80000000 / −1 → 0x80000000, `over` = 1.
- DIV 5 / 0 → `out` = 0xFFFFFFFF, `div_zero` = 1, latency 33. REM 5 / 0 → `out` = 5.
- Backpressure: LT −1 < 1 → `out` = 1. Hold `out_ready` = 0 for 10 cycles: `out_valid`/`out` stay stable and `in_ready` = 0. Pulse `out_ready`: the next cycle is IDLE with `in_ready` = 1.
- Assert `rst` mid-MUL (cycle 10 of BUSY) → `out_valid` = 0 and `in_ready` = 1 immediately. A subsequent ADD 2 + 3 returns 5 with correct latency.
